// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: decodes requests, strobes the execution units, and
// schedules results onto a single writeback port through a reservation shift register.
module fpu_issue_ctrl #(
  parameter int unsigned LAT_SGNJ = 1,
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 2,
  parameter int unsigned LAT_DIV  = 10,
  parameter int unsigned TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             sgnj_go,
  output logic             add_go,
  output logic             mul_go,
  output logic             div_go,
  output logic [1:0]       op_mode,
  output logic             wb_valid,
  output logic [1:0]       wb_unit,
  output logic [TAG_W-1:0] wb_tag,
  output logic             busy
);

  localparam int unsigned NSLOT = LAT_DIV + 1;
  localparam int unsigned IDX_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int unsigned CNT_W = (LAT_DIV > 1) ? $clog2(LAT_DIV + 1) : 1;

  localparam logic [1:0] UNIT_SGNJ = 2'd0;
  localparam logic [1:0] UNIT_ADD  = 2'd1;
  localparam logic [1:0] UNIT_MUL  = 2'd2;
  localparam logic [1:0] UNIT_DIV  = 2'd3;

  // Slot i holds the writeback due i cycles from now; slot 0 drives wb_*.
  logic             slot_vld_q  [NSLOT];
  logic             slot_vld_d  [NSLOT];
  logic [1:0]       slot_unit_q [NSLOT];
  logic [1:0]       slot_unit_d [NSLOT];
  logic [TAG_W-1:0] slot_tag_q  [NSLOT];
  logic [TAG_W-1:0] slot_tag_d  [NSLOT];
  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;
  logic             busy_q;
  logic             busy_d;

  logic [1:0]       unit_c;
  logic [1:0]       mode_c;
  logic [IDX_W-1:0] lat_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic             is_div_c;
  logic             accept_c;

  // Opcode decode into target unit, latency and sub-op.
  always_comb begin
    unit_c   = UNIT_SGNJ;
    mode_c   = 2'd0;
    lat_c    = IDX_W'(LAT_SGNJ);
    is_div_c = 1'b0;
    case (req_op)
      3'd0, 3'd1, 3'd2: begin
        unit_c = UNIT_SGNJ;
        mode_c = req_op[1:0];
        lat_c  = IDX_W'(LAT_SGNJ);
      end
      3'd3, 3'd4: begin
        unit_c = UNIT_ADD;
        mode_c = {1'b0, req_op == 3'd4};
        lat_c  = IDX_W'(LAT_ADD);
      end
      3'd5: begin
        unit_c = UNIT_MUL;
        lat_c  = IDX_W'(LAT_MUL);
      end
      default: begin
        unit_c   = UNIT_DIV;
        mode_c   = {1'b0, req_op == 3'd7};
        lat_c    = IDX_W'(LAT_DIV);
        is_div_c = 1'b1;
      end
    endcase
  end

  // Ready looks only at op, reservation state, div occupancy, flush and reset.
  always_comb begin
    req_ready = rstn & ~flush & ~slot_vld_q[lat_c] & ~(is_div_c & (div_cnt_q != '0));
    accept_c  = req_valid & req_ready;
    wr_idx_c  = lat_c - IDX_W'(1);
    sgnj_go   = accept_c & (unit_c == UNIT_SGNJ);
    add_go    = accept_c & (unit_c == UNIT_ADD);
    mul_go    = accept_c & (unit_c == UNIT_MUL);
    div_go    = accept_c & (unit_c == UNIT_DIV);
    op_mode   = accept_c ? mode_c : 2'd0;
  end

  // Advance reservations, insert the accepted op, apply flush.
  always_comb begin
    for (int i = 0; i < int'(NSLOT) - 1; i++) begin
      slot_vld_d[i]  = slot_vld_q[i+1];
      slot_unit_d[i] = slot_unit_q[i+1];
      slot_tag_d[i]  = slot_tag_q[i+1];
    end
    slot_vld_d[NSLOT-1]  = 1'b0;
    slot_unit_d[NSLOT-1] = 2'd0;
    slot_tag_d[NSLOT-1]  = '0;
    div_cnt_d = (div_cnt_q != '0) ? div_cnt_q - CNT_W'(1) : '0;
    if (accept_c) begin
      slot_vld_d[wr_idx_c]  = 1'b1;
      slot_unit_d[wr_idx_c] = unit_c;
      slot_tag_d[wr_idx_c]  = req_tag;
      if (is_div_c) div_cnt_d = CNT_W'(LAT_DIV - 1);
    end
    if (flush) begin
      for (int i = 0; i < int'(NSLOT); i++) begin
        slot_vld_d[i]  = 1'b0;
        slot_unit_d[i] = 2'd0;
        slot_tag_d[i]  = '0;
      end
      div_cnt_d = '0;
    end
    busy_d = (div_cnt_d != '0);
    for (int i = 0; i < int'(NSLOT); i++) busy_d = busy_d | slot_vld_d[i];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot_vld_q  <= '{default: 1'b0};
      slot_unit_q <= '{default: 2'd0};
      slot_tag_q  <= '{default: '0};
      div_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_unit_q <= slot_unit_d;
      slot_tag_q  <= slot_tag_d;
      div_cnt_q   <= div_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign wb_valid = slot_vld_q[0];
  assign wb_unit  = slot_unit_q[0];
  assign wb_tag   = slot_tag_q[0];
  assign busy     = busy_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scenario bench for fpu_issue_ctrl: per-feature tasks plus a writeback scoreboard
// keyed by the cycle each result is due.
module tb_fpu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [4:0] req_tag;
  logic       sgnj_go, add_go, mul_go, div_go;
  logic [1:0] op_mode;
  logic       wb_valid;
  logic [1:0] wb_unit;
  logic [4:0] wb_tag;
  logic       busy;

  fpu_issue_ctrl dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
    .sgnj_go(sgnj_go), .add_go(add_go), .mul_go(mul_go), .div_go(div_go),
    .op_mode(op_mode), .wb_valid(wb_valid), .wb_unit(wb_unit), .wb_tag(wb_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] unit;
    logic [4:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // One cycle: drive, sample mid-cycle, score the writeback port, advance.
  task automatic step(input logic v, input logic [2:0] op, input logic [4:0] tag, input logic fl,
                      output logic rdy, output logic [3:0] gos, output logic [1:0] mode,
                      output logic bsy);
    int idx;
    req_valid = v; req_op = op; req_tag = tag; flush = fl;
    @(negedge clk);
    rdy  = req_ready;
    gos  = {div_go, mul_go, add_go, sgnj_go};
    mode = op_mode;
    bsy  = busy;
    idx  = -1;
    for (int i = 0; i < sb_q.size(); i++) if (sb_q[i].cyc == cyc) idx = i;
    checks++;
    if (idx >= 0) begin
      if (wb_valid !== 1'b1 || wb_unit !== sb_q[idx].unit || wb_tag !== sb_q[idx].tag) begin
        failures++;
        $display("FAIL wb_c%0d: valid=%b unit=%0d tag=%0d required valid=1 unit=%0d tag=%0d",
                 cyc, wb_valid, wb_unit, wb_tag, sb_q[idx].unit, sb_q[idx].tag);
      end
      sb_q.delete(idx);
    end else if (wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL wb_idle_c%0d: valid=%b tag=%0d required valid=0", cyc, wb_valid, wb_tag);
    end
    if (fl) for (int i = sb_q.size() - 1; i >= 0; i--) if (sb_q[i].cyc > cyc) sb_q.delete(i);
    @(posedge clk);
    #1;
    cyc++;
    req_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic drain(input int n);
    logic r, b; logic [3:0] g; logic [1:0] m;
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 5'd0, 1'b0, r, g, m, b);
  endtask

  task automatic test_reset();
    logic r, b; logic [3:0] g; logic [1:0] m;
    step(1'b1, 3'd3, 5'd1, 1'b0, r, g, m, b);
    checks++;
    if (r !== 1'b0 || g !== 4'b0000 || m !== 2'd0 || b !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b go=%b mode=%0d busy=%b required 0 0000 0 0", r, g, m, b);
    end
    rstn = 1'b1;
  endtask

  task automatic test_add();
    logic r, b; logic [3:0] g; logic [1:0] m;
    step(1'b1, 3'd3, 5'd3, 1'b0, r, g, m, b);
    sb_q.push_back('{cyc - 1 + 3, 2'd1, 5'd3});
    checks++;
    if (r !== 1'b1 || g !== 4'b0010 || m !== 2'd0) begin
      failures++;
      $display("FAIL add_issue: ready=%b go=%b mode=%0d required 1 0010 0", r, g, m);
    end
    step(1'b0, 3'd0, 5'd0, 1'b0, r, g, m, b);
    checks++;
    if (b !== 1'b1) begin failures++; $display("FAIL add_busy: busy=%b required 1", b); end
    drain(5);
    step(1'b0, 3'd0, 5'd0, 1'b0, r, g, m, b);
    checks++;
    if (b !== 1'b0) begin failures++; $display("FAIL add_idle_busy: busy=%b required 0", b); end
  endtask

  task automatic test_div_stall();
    logic r, b; logic [3:0] g; logic [1:0] m;
    int base;
    base = cyc;
    step(1'b1, 3'd6, 5'd7, 1'b0, r, g, m, b);
    sb_q.push_back('{base + 10, 2'd3, 5'd7});
    checks++;
    if (r !== 1'b1 || g !== 4'b1000 || m !== 2'd0) begin
      failures++;
      $display("FAIL div_issue: ready=%b go=%b mode=%0d required 1 1000 0", r, g, m);
    end
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 3'd6, 5'd8, 1'b0, r, g, m, b);
      checks++;
      if (r !== 1'b0 || g !== 4'b0000) begin
        failures++;
        $display("FAIL div_stall_c%0d: ready=%b go=%b required 0 0000", k, r, g);
      end
    end
    step(1'b1, 3'd6, 5'd8, 1'b0, r, g, m, b);
    sb_q.push_back('{base + 20, 2'd3, 5'd8});
    checks++;
    if (r !== 1'b1 || g !== 4'b1000) begin
      failures++;
      $display("FAIL div_second_issue: ready=%b go=%b required 1 1000", r, g);
    end
    drain(12);
  endtask

  task automatic test_conflict();
    logic r, b; logic [3:0] g; logic [1:0] m;
    int base;
    base = cyc;
    step(1'b1, 3'd5, 5'd1, 1'b0, r, g, m, b);
    sb_q.push_back('{base + 2, 2'd2, 5'd1});
    checks++;
    if (r !== 1'b1 || g !== 4'b0100 || m !== 2'd0) begin
      failures++;
      $display("FAIL mul_issue: ready=%b go=%b mode=%0d required 1 0100 0", r, g, m);
    end
    step(1'b1, 3'd2, 5'd2, 1'b0, r, g, m, b);
    checks++;
    if (r !== 1'b0 || g !== 4'b0000) begin
      failures++;
      $display("FAIL sgnj_conflict: ready=%b go=%b required 0 0000", r, g);
    end
    step(1'b1, 3'd2, 5'd2, 1'b0, r, g, m, b);
    sb_q.push_back('{base + 3, 2'd0, 5'd2});
    checks++;
    if (r !== 1'b1 || g !== 4'b0001 || m !== 2'd2) begin
      failures++;
      $display("FAIL sgnjx_issue: ready=%b go=%b mode=%0d required 1 0001 2", r, g, m);
    end
    drain(4);
  endtask

  task automatic test_back_to_back();
    logic r, b; logic [3:0] g; logic [1:0] m;
    logic [2:0] op;
    int base;
    base = cyc;
    for (int k = 0; k < 16; k++) begin
      op = (k % 4 == 3) ? 3'd4 : 3'd3;
      step(1'b1, op, 5'(k), 1'b0, r, g, m, b);
      sb_q.push_back('{base + k + 3, 2'd1, 5'(k)});
      checks++;
      if (r !== 1'b1 || g !== 4'b0010 || m !== ((op == 3'd4) ? 2'd1 : 2'd0)) begin
        failures++;
        $display("FAIL b2b_issue_k%0d: ready=%b go=%b mode=%0d", k, r, g, m);
      end
    end
    drain(5);
  endtask

  task automatic test_flush();
    logic r, b; logic [3:0] g; logic [1:0] m;
    int base;
    base = cyc;
    step(1'b1, 3'd7, 5'd4, 1'b0, r, g, m, b);
    sb_q.push_back('{base + 10, 2'd3, 5'd4});
    checks++;
    if (r !== 1'b1 || g !== 4'b1000 || m !== 2'd1) begin
      failures++;
      $display("FAIL sqrt_issue: ready=%b go=%b mode=%0d required 1 1000 1", r, g, m);
    end
    drain(3);
    step(1'b0, 3'd0, 5'd0, 1'b0, r, g, m, b);
    checks++;
    if (b !== 1'b1) begin failures++; $display("FAIL sqrt_busy: busy=%b required 1", b); end
    step(1'b1, 3'd3, 5'd9, 1'b1, r, g, m, b);
    checks++;
    if (r !== 1'b0 || g !== 4'b0000) begin
      failures++;
      $display("FAIL flush_blocks_req: ready=%b go=%b required 0 0000", r, g);
    end
    for (int k = 6; k <= 12; k++) begin
      step(1'b0, 3'd0, 5'd0, 1'b0, r, g, m, b);
      checks++;
      if (b !== 1'b0) begin failures++; $display("FAIL flush_busy_c%0d: busy=%b required 0", k, b); end
    end
    // A result already on the port in the flush cycle still counts.
    base = cyc;
    step(1'b1, 3'd3, 5'd5, 1'b0, r, g, m, b);
    sb_q.push_back('{base + 3, 2'd1, 5'd5});
    step(1'b1, 3'd6, 5'd6, 1'b0, r, g, m, b);
    sb_q.push_back('{base + 11, 2'd3, 5'd6});
    drain(1);
    step(1'b0, 3'd0, 5'd0, 1'b1, r, g, m, b);
    drain(10);
  endtask

  task automatic test_reset_mid();
    logic r, b; logic [3:0] g; logic [1:0] m;
    drain(1);
    step(1'b1, 3'd3, 5'd10, 1'b0, r, g, m, b);
    sb_q.push_back('{cyc - 1 + 3, 2'd1, 5'd10});
    rstn = 1'b0;
    step(1'b0, 3'd0, 5'd0, 1'b0, r, g, m, b);
    sb_q.delete();
    step(1'b1, 3'd3, 5'd12, 1'b0, r, g, m, b);
    checks++;
    if (r !== 1'b0 || g !== 4'b0000 || m !== 2'd0 || b !== 1'b0 || wb_unit !== 2'd0 || wb_tag !== 5'd0) begin
      failures++;
      $display("FAIL midreset_outputs: ready=%b go=%b mode=%0d busy=%b unit=%0d tag=%0d required all 0",
               r, g, m, b, wb_unit, wb_tag);
    end
    rstn = 1'b1;
    step(1'b1, 3'd0, 5'd11, 1'b0, r, g, m, b);
    sb_q.push_back('{cyc - 1 + 1, 2'd0, 5'd11});
    checks++;
    if (r !== 1'b1 || g !== 4'b0001 || m !== 2'd0) begin
      failures++;
      $display("FAIL first_after_reset: ready=%b go=%b mode=%0d required 1 0001 0", r, g, m);
    end
    drain(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_tag = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_div_stall();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    checks++;
    if (sb_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_empty: pending=%0d required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter LAT_SGNJ, default 1, meaning issue-to-writeback latency (cycles) of the sign-injection unit.
REQ-002 SHALL have parameter LAT_ADD, default 3, meaning latency of the pipelined add/sub unit.
REQ-003 SHALL have parameter LAT_MUL, default 2, meaning latency of the pipelined multiply unit.
REQ-004 SHALL have parameter LAT_DIV, default 10, meaning latency of the iterative, non-pipelined div/sqrt unit.
REQ-005 SHALL have parameter TAG_W, default 5, meaning destination-register tag width.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rstn  input  1  reset, synchronous and active-low.
REQ-008 flush  input  1  kill all in-flight operations.
REQ-009 req_valid  input  1  request present.
REQ-010 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-011 req_op  input  3  0 fsgnj, 1 fsgnjn, 2 fsgnjx, 3 fadd, 4 fsub, 5 fmul, 6 fdiv, 7 fsqrt.
REQ-012 req_tag  input  TAG_W  destination tag.
REQ-013 sgnj_go / add_go / mul_go / div_go  output  1 each  single-cycle start strobes to the units.
REQ-014 op_mode  output  2  sub-op to started unit: sgnj 0/1/2 = j/jn/jx; add 0 add, 1 sub; div 0 div, 1 sqrt; mul 0.
REQ-015 wb_valid  output  1  result writeback this cycle.
REQ-016 wb_unit  output  2  result mux select: 0 sgnj, 1 add, 2 mul, 3 div.
REQ-017 wb_tag  output  TAG_W  tag of the writeback.
REQ-018 busy  output  1  any operation in flight.

Function
REQ-019 Acceptance SHALL occur in a cycle where req_valid && req_ready; the matching *_go and op_mode SHALL be asserted combinationally in that same cycle, exactly one *_go high, all low otherwise.
REQ-020 Single writeback port: a reservation shift register of LAT_DIV+1 slots, each holding {valid, unit, tag}, SHALL advance one slot per cycle toward slot 0.
REQ-021 Accepting op with latency L SHALL write slot L, so wb_valid/wb_unit/wb_tag appear exactly L cycles after the accepting edge.
REQ-022 req_ready SHALL be low if slot L (after this cycle's shift) is already reserved (writeback conflict).
REQ-023 req_ready SHALL be low for ops 6/7 while the div unit is busy; div busy SHALL last LAT_DIV cycles from acceptance, a new div acceptable in the cycle its predecessor writes back.
REQ-024 req_ready SHALL be low during reset and in any cycle flush is high; flush SHALL win over a simultaneous request.
REQ-025 Flush SHALL clear all slots and div busy at the edge; no wb_valid from the next cycle onward for killed ops; a writeback already on wb_* in the flush cycle SHALL remain valid.
REQ-026 Add and mul SHALL accept back-to-back every cycle absent conflicts (pipelined units).
REQ-027 busy SHALL be high when any slot is valid or div busy; it SHALL be low otherwise.
REQ-028 req_ready SHALL be independent of req_tag; it SHALL depend only on req_op, state, flush, rstn.
REQ-029 No request SHALL be lost or duplicated; each accepted op SHALL produce exactly one writeback unless flushed.

Reset
REQ-030 When rstn low at an edge, all slots, div busy and outputs wb_valid, wb_unit, wb_tag, busy SHALL be 0; *_go and op_mode SHALL be 0 while rstn low.
REQ-031 Reset mid-operation SHALL discard all in-flight ops with no later writeback.
REQ-032 First acceptance SHALL be possible in the first cycle with rstn high.

Verification
REQ-033 fadd tag 3 at cycle 0 -> add_go=1, op_mode=0 at cycle 0; wb_valid=1, wb_unit=1, wb_tag=3 at cycle 3 only.
REQ-034 fdiv tag 7 at 0, fdiv tag 8 at 1 -> second stalls (req_ready=0) cycles 1-9, accepted at 10; writebacks at 10 (tag 7) and 20 (tag 8).
REQ-035 fmul tag 1 at 0, fsgnjx tag 2 at 1 -> both target slot 2; sgnj stalls at 1, accepted at 2 with op_mode=2; writebacks tag 1 at 2, tag 2 at 3.
REQ-036 fadd every cycle, tags 0..15, cycles 0..15 -> req_ready always 1; wb_tag k at cycle k+3.
REQ-037 fsqrt tag 4 at 0, flush at 5 with fadd request -> fadd not accepted at 5; no wb_valid cycles 6-12; busy=0 from cycle 6.
REQ-038 rstn low at cycle 2 with fadd accepted at 1 -> no wb_valid at 4; all outputs 0; fsgnj accepted in first cycle after rstn rises, writeback 1 cycle later.
